// File: rtl/demux_pkg.sv
// Shared select encoding for the 1:4 demultiplexer.
package demux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_O1 = 2'b00;
    localparam sel_t SEL_O2 = 2'b01;
    localparam sel_t SEL_O3 = 2'b10;
    localparam sel_t SEL_O4 = 2'b11;

endpackage

// File: rtl/demux_1to2.sv
// Combinational 1:2 routing stage; the unselected leg is driven to zero.
module demux_1to2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic             sel_in,
    output logic [WIDTH-1:0] y0_out,
    output logic [WIDTH-1:0] y1_out
);

    always_comb begin
        y0_out = '0;
        y1_out = '0;
        if (sel_in) begin
            y1_out = a_in;
        end else begin
            y0_out = a_in;
        end
    end

endmodule

// File: rtl/demux.sv
// Registered 1:4 demultiplexer built from a tree of 1:2 stages.
module demux
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic             s0_in,
    input  logic             s1_in,
    output logic [WIDTH-1:0] o1_out,
    output logic [WIDTH-1:0] o2_out,
    output logic [WIDTH-1:0] o3_out,
    output logic [WIDTH-1:0] o4_out,
    output logic             n1_out,
    output logic             n2_out
);

    sel_t sel;
    logic [WIDTH-1:0] lo, hi;
    logic [WIDTH-1:0] r1, r2, r3, r4;
    logic [WIDTH-1:0] o1_d, o2_d, o3_d, o4_d;
    logic [WIDTH-1:0] o1_q, o2_q, o3_q, o4_q;
    logic             n1_d, n2_d, n1_q, n2_q;

    assign sel = {s1_in, s0_in};

    // s1 splits the upper/lower pair, s0 picks within each pair
    demux_1to2 #(.WIDTH(WIDTH)) u_root (
        .a_in  (a_in),
        .sel_in(sel[1]),
        .y0_out(lo),
        .y1_out(hi)
    );

    demux_1to2 #(.WIDTH(WIDTH)) u_leaf_lo (
        .a_in  (lo),
        .sel_in(sel[0]),
        .y0_out(r1),
        .y1_out(r2)
    );

    demux_1to2 #(.WIDTH(WIDTH)) u_leaf_hi (
        .a_in  (hi),
        .sel_in(sel[0]),
        .y0_out(r3),
        .y1_out(r4)
    );

    always_comb begin
        o1_d = r1;
        o2_d = r2;
        o3_d = r3;
        o4_d = r4;
        n1_d = ~sel[0];
        n2_d = ~sel[1];
        if (rst_in) begin
            o1_d = '0;
            o2_d = '0;
            o3_d = '0;
            o4_d = '0;
            n1_d = 1'b1;
            n2_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        o1_q <= o1_d;
        o2_q <= o2_d;
        o3_q <= o3_d;
        o4_q <= o4_d;
        n1_q <= n1_d;
        n2_q <= n2_d;
    end

    assign o1_out = o1_q;
    assign o2_out = o2_q;
    assign o3_out = o3_q;
    assign o4_out = o4_q;
    assign n1_out = n1_q;
    assign n2_out = n2_q;

endmodule

// File: tb/tb_demux.sv
// Scoreboard bench: WIDTH=1 and WIDTH=8 instances share clock, reset and selects.
module tb_demux;
    import demux_pkg::*;

    typedef struct packed {
        logic [7:0] o1, o2, o3, o4;
        logic       n1, n2;
    } obs8_t;

    typedef struct packed {
        logic o1, o2, o3, o4;
        logic n1, n2;
    } obs1_t;

    typedef struct packed {
        obs8_t w8;
        obs1_t w1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a8 = '0;
    logic       a1 = 1'b0;
    logic       s0 = 1'b0;
    logic       s1 = 1'b0;

    logic [7:0] p1, p2, p3, p4;
    logic       pn1, pn2;
    logic       q1, q2, q3, q4;
    logic       qn1, qn2;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    demux #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst), .a_in(a8),
        .s0_in(s0), .s1_in(s1),
        .o1_out(p1), .o2_out(p2), .o3_out(p3), .o4_out(p4),
        .n1_out(pn1), .n2_out(pn2)
    );

    demux #(.WIDTH(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .a_in(a1),
        .s0_in(s0), .s1_in(s1),
        .o1_out(q1), .o2_out(q2), .o3_out(q3), .o4_out(q4),
        .n1_out(qn1), .n2_out(qn2)
    );

    function automatic exp_t model(logic r, logic [7:0] d8, logic d1, sel_t s);
        exp_t e;
        e = '0;
        e.w8.n1 = 1'b1;
        e.w8.n2 = 1'b1;
        e.w1.n1 = 1'b1;
        e.w1.n2 = 1'b1;
        if (!r) begin
            case (s)
                SEL_O1: begin e.w8.o1 = d8; e.w1.o1 = d1; end
                SEL_O2: begin e.w8.o2 = d8; e.w1.o2 = d1; end
                SEL_O3: begin e.w8.o3 = d8; e.w1.o3 = d1; end
                default: begin e.w8.o4 = d8; e.w1.o4 = d1; end
            endcase
            e.w8.n1 = (s != SEL_O2) && (s != SEL_O4);
            e.w8.n2 = (s == SEL_O1) || (s == SEL_O2);
            e.w1.n1 = e.w8.n1;
            e.w1.n2 = e.w8.n2;
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, record its expectation, step past the edge.
    task automatic drive(input logic r, input logic [7:0] d8, input logic d1,
                         input sel_t s);
        @(negedge clk);
        rst = r;
        a8  = d8;
        a1  = d1;
        {s1, s0} = s;
        q.push_back(model(r, d8, d1, s));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hFF, 1'b1, SEL_O4);
            e = q.pop_front();
            vectors++;
            if ({p1, p2, p3, p4, pn1, pn2} !== e.w8
                || {q1, q2, q3, q4, qn1, qn2} !== e.w1) begin
                miscompares++;
                $display("FAIL reset[%0d] got w8=%h w1=%b need w8=%h w1=%b",
                         i, {p1, p2, p3, p4, pn1, pn2},
                         {q1, q2, q3, q4, qn1, qn2}, e.w8, e.w1);
            end
        end
    endtask

    task automatic test_sweep(input logic [7:0] d8, input logic d1, input string nm);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, d8, d1, sel_t'(s));
            e = q.pop_front();
            vectors++;
            if ({p1, p2, p3, p4, pn1, pn2} !== e.w8
                || {q1, q2, q3, q4, qn1, qn2} !== e.w1) begin
                miscompares++;
                $display("FAIL %s sel=%0d got w8=%h w1=%b need w8=%h w1=%b",
                         nm, s, {p1, p2, p3, p4, pn1, pn2},
                         {q1, q2, q3, q4, qn1, qn2}, e.w8, e.w1);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel_t seq [4] = '{SEL_O1, SEL_O4, SEL_O2, SEL_O3};
        logic [7:0] dat [4] = '{8'h3C, 8'hC3, 8'h81, 8'h7E};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, dat[i], dat[i][0] ^ i[0], seq[i]);
            e = q.pop_front();
            vectors++;
            if ({p1, p2, p3, p4, pn1, pn2} !== e.w8
                || {q1, q2, q3, q4, qn1, qn2} !== e.w1) begin
                miscompares++;
                $display("FAIL b2b[%0d] got w8=%h w1=%b need w8=%h w1=%b",
                         i, {p1, p2, p3, p4, pn1, pn2},
                         {q1, q2, q3, q4, qn1, qn2}, e.w8, e.w1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       rs [3] = '{1'b0, 1'b1, 1'b0};
        sel_t       ss [3] = '{SEL_O3, SEL_O3, SEL_O2};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(rs[i], 8'h5A, 1'b1, ss[i]);
            e = q.pop_front();
            vectors++;
            if ({p1, p2, p3, p4, pn1, pn2} !== e.w8
                || {q1, q2, q3, q4, qn1, qn2} !== e.w1) begin
                miscompares++;
                $display("FAIL rst_mid[%0d] got w8=%h w1=%b need w8=%h w1=%b",
                         i, {p1, p2, p3, p4, pn1, pn2},
                         {q1, q2, q3, q4, qn1, qn2}, e.w8, e.w1);
            end
        end
    endtask

    task automatic test_width8();
        exp_t e;
        drive(1'b0, 8'hA5, 1'b1, SEL_O2);
        e = q.pop_front();
        vectors++;
        if (p2 !== 8'hA5 || {p1, p3, p4} !== 24'h0
            || {p1, p2, p3, p4, pn1, pn2} !== e.w8) begin
            miscompares++;
            $display("FAIL w8_a5 got w8=%h need w8=%h",
                     {p1, p2, p3, p4, pn1, pn2}, e.w8);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'($urandom), 1'($urandom), sel_t'($urandom_range(0, 3)));
            e = q.pop_front();
            vectors++;
            if ({p1, p2, p3, p4, pn1, pn2} !== e.w8
                || {q1, q2, q3, q4, qn1, qn2} !== e.w1) begin
                miscompares++;
                $display("FAIL rand[%0d] got w8=%h w1=%b need w8=%h w1=%b",
                         i, {p1, p2, p3, p4, pn1, pn2},
                         {q1, q2, q3, q4, qn1, qn2}, e.w8, e.w1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep(8'hFF, 1'b1, "sweep");
        test_sweep(8'h00, 1'b0, "zero");
        test_back_to_back();
        test_reset_mid();
        test_width8();
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter WIDTH SHALL have default 1 and SHALL set the data width of a_in and of o1_out..o4_out; legal range is 1..64.
REQ-002 Port clk_in SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_in SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port a_in SHALL be an input, WIDTH bits: the data to be routed.
REQ-005 Port s0_in SHALL be an input, 1 bit: select LSB.
REQ-006 Port s1_in SHALL be an input, 1 bit: select MSB.
REQ-007 Port o1_out SHALL be an output, WIDTH bits: channel 0, selected by code {s1,s0}=00.
REQ-008 Port o2_out SHALL be an output, WIDTH bits: channel 1, selected by code 01 (s0=1, s1=0).
REQ-009 Port o3_out SHALL be an output, WIDTH bits: channel 2, selected by code 10 (s0=0, s1=1).
REQ-010 Port o4_out SHALL be an output, WIDTH bits: channel 3, selected by code 11.
REQ-011 Port n1_out SHALL be an output, 1 bit: registered complement of s0_in.
REQ-012 Port n2_out SHALL be an output, 1 bit: registered complement of s1_in.

Function
REQ-013 The select code SHALL be sel = {s1_in, s0_in}, an unsigned 2-bit value.
REQ-014 On each rising clk_in with rst_in low, the output indexed by sel SHALL load a_in, and the other three outputs SHALL load all-zeros.
REQ-015 Latency SHALL be exactly one clock from a_in/s0_in/s1_in to o1_out..o4_out, n1_out and n2_out; no combinational path from any input to any output.
REQ-016 At most one of o1_out..o4_out SHALL be nonzero in any cycle (one-hot routing; zero data yields all-zero outputs).
REQ-017 A select change SHALL take effect in the next cycle with no intermediate or glitch cycle; the previously selected channel SHALL drop to zero in the same cycle the new channel loads.
REQ-018 n1_out and n2_out SHALL update in the same cycle as the data outputs, so {~n2_out, ~n1_out} always equals the select code that produced the current outputs.
REQ-019 No X-propagation handling SHALL be performed; behaviour for X/Z inputs is not specified.

Reset
REQ-020 While rst_in is high at a rising clk_in, o1_out..o4_out SHALL become 0 and n1_out and n2_out SHALL become 1, regardless of the other inputs.
REQ-021 Reset SHALL take priority over routing; the first cycle after rst_in is deasserted SHALL route normally from the inputs sampled at that edge.
REQ-022 Asserting rst_in in the middle of operation SHALL clear all outputs at that edge, with no residual data.

Structure
REQ-023 Package demux_pkg SHALL hold the 2-bit select typedef sel_t and the constants SEL_O1=2'b00, SEL_O2=2'b01, SEL_O3=2'b10 and SEL_O4=2'b11.
REQ-024 Sub-module demux_1to2 SHALL be a combinational 1:2 stage, parameterised by WIDTH; demux SHALL instantiate three of them as a tree, with s1 at the root and s0 at the leaves, followed by one output register bank in the top.

Verification
REQ-025 Reset: hold rst_in=1 for 2 clocks with a_in=1 and sel=11 -> o1..o4=0 and n1=n2=1.
REQ-026 Sweep, WIDTH=1, a_in=1: sel 00, 01, 10, 11 each held for one clock -> next-cycle one-hot outputs o1, o2, o3, o4 respectively, with (n1,n2)=(1,1),(0,1),(1,0),(0,0).
REQ-027 Zero data: a_in=0 across all four select codes -> all outputs 0; n1 and n2 still track the select.
REQ-028 Back-to-back select changes every cycle (00->11->01->10) -> each cycle exactly the indexed output equals the a_in of the previous cycle, with no overlap.
REQ-029 Reset mid-stream: sel=10 with a_in=1, then rst_in=1 for one cycle -> o3 cleared at that edge, n1=n2=1; after release, routing resumes on the next edge.
REQ-030 WIDTH=8: a_in=8'hA5 with sel=01 -> o2_out=8'hA5 and the other outputs 8'h00.
